// File: rtl/dram_readout_addr_gen.sv
// Triggered DRAM readout address generator: one read per (sample, board, channel) from backed-off ring offsets, valid/ready held under stall.
// First request the cycle after the trigger edge; define RDGEN_RETRIGGER_EN to queue one trigger while busy instead of dropping it.
module dram_readout_addr_gen #(
  parameter int NUM_BOARDS         = 8,
  parameter int CHANNELS_PER_BOARD = 125,
  parameter int OFFSET_W           = 14,
  parameter int SAMPLES            = 1250,
  parameter int PRE_TRIG           = 0,
  parameter int ADDR_W             = 25,
  parameter int DATA_W             = 256
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           trig,
  input  logic [NUM_BOARDS*OFFSET_W-1:0] trig_offsets,
  output logic                           rd_valid,
  input  logic                           rd_ready,
  output logic [ADDR_W-1:0]              rd_addr,
  input  logic [DATA_W-1:0]              dram_rd_data,
  input  logic                           dram_rd_valid,
  output logic [DATA_W-1:0]              pc_data,
  output logic                           pc_valid,
  output logic                           busy,
  output logic                           done,
  output logic [15:0]                    drop_count
);

  localparam int BOARD_W = $clog2(NUM_BOARDS);
  localparam int CH_W    = $clog2(CHANNELS_PER_BOARD);
  localparam int TOTAL   = NUM_BOARDS * CHANNELS_PER_BOARD * SAMPLES;
  localparam int CNT_W   = $clog2(TOTAL + 1);
  localparam int SMP_W   = $clog2(SAMPLES + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t              state, state_nxt;
  logic [OFFSET_W-1:0] base [NUM_BOARDS];
  logic [OFFSET_W-1:0] snap [NUM_BOARDS];
  logic [SMP_W-1:0]    sample_idx;
  logic [BOARD_W-1:0]  board_idx;
  logic [CH_W-1:0]     ch_idx;
  logic [CNT_W-1:0]    ret_cnt, ret_cnt_nxt;
  logic [OFFSET_W-1:0] cur_off;
  logic                start, drop, done_nxt, handshake, last_tuple;
`ifdef RDGEN_RETRIGGER_EN
  logic                pending, use_pend, pend_set;
  logic [OFFSET_W-1:0] pend_base [NUM_BOARDS];
`endif

  assign rd_valid   = (state == ISSUE);
  assign busy       = (state != IDLE);
  assign handshake  = rd_valid & rd_ready;
  assign last_tuple = (sample_idx == SMP_W'(SAMPLES - 1)) &&
                      (board_idx  == BOARD_W'(NUM_BOARDS - 1)) &&
                      (ch_idx     == CH_W'(CHANNELS_PER_BOARD - 1));
  // Offset add wraps naturally, walking the ring buffer past its end.
  assign cur_off    = base[board_idx] + OFFSET_W'(sample_idx);
  assign rd_addr    = ADDR_W'({board_idx, ch_idx, cur_off});
  assign pc_data    = dram_rd_data;
  assign pc_valid   = dram_rd_valid;

  always_comb begin
    for (int b = 0; b < NUM_BOARDS; b++) begin
      snap[b] = trig_offsets[b*OFFSET_W +: OFFSET_W] - OFFSET_W'(PRE_TRIG);
    end
  end

  always_comb begin
    ret_cnt_nxt = ret_cnt;
    if (dram_rd_valid && (ret_cnt != CNT_W'(TOTAL))) begin
      ret_cnt_nxt = ret_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    drop      = 1'b0;
    done_nxt  = 1'b0;
`ifdef RDGEN_RETRIGGER_EN
    use_pend  = 1'b0;
    pend_set  = 1'b0;
`endif
    case (state)
      IDLE: begin
`ifdef RDGEN_RETRIGGER_EN
        // A queued trigger wins; a fresh trig in the same cycle has nowhere to go.
        if (pending) begin
          start    = 1'b1;
          use_pend = 1'b1;
          drop     = trig;
        end else begin
          start = trig;
        end
`else
        start = trig;
`endif
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (handshake && last_tuple) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (ret_cnt_nxt == CNT_W'(TOTAL)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    if ((state != IDLE) && trig) begin
`ifdef RDGEN_RETRIGGER_EN
      if (pending) drop = 1'b1;
      else         pend_set = 1'b1;
`else
      drop = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sample_idx <= '0;
      board_idx  <= '0;
      ch_idx     <= '0;
      ret_cnt    <= '0;
    end else begin
      ret_cnt <= start ? '0 : ret_cnt_nxt;
      if (start) begin
        sample_idx <= '0;
        board_idx  <= '0;
        ch_idx     <= '0;
      end else if (handshake && !last_tuple) begin
        if (ch_idx == CH_W'(CHANNELS_PER_BOARD - 1)) begin
          ch_idx <= '0;
          if (board_idx == BOARD_W'(NUM_BOARDS - 1)) begin
            board_idx  <= '0;
            sample_idx <= sample_idx + SMP_W'(1);
          end else begin
            board_idx <= board_idx + BOARD_W'(1);
          end
        end else begin
          ch_idx <= ch_idx + CH_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int b = 0; b < NUM_BOARDS; b++) base[b] <= '0;
    end else if (start) begin
      for (int b = 0; b < NUM_BOARDS; b++) begin
`ifdef RDGEN_RETRIGGER_EN
        base[b] <= use_pend ? pend_base[b] : snap[b];
`else
        base[b] <= snap[b];
`endif
      end
    end
  end

`ifdef RDGEN_RETRIGGER_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= 1'b0;
      for (int b = 0; b < NUM_BOARDS; b++) pend_base[b] <= '0;
    end else if (pend_set) begin
      pending <= 1'b1;
      for (int b = 0; b < NUM_BOARDS; b++) pend_base[b] <= snap[b];
    end else if (use_pend) begin
      pending <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= '0;
    end else if (drop && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end

endmodule

// File: doc/dram_readout_addr_gen.md
# dram_readout_addr_gen

Parametrised readout address generator for the triggered DRAM capture path. On a trigger it snapshots each board's ring-buffer write offset, backs it off by a programmable pre-trigger depth, and issues one DRAM read per (sample, board, channel) with valid/ready flow control. Returned read data is forwarded to the PC link, and completion is reported when the final beat returns. It sits between the trigger logic and the DRAM read port, and supersedes the fixed 8-board/125-channel generator.

## Interface
- `NUM_BOARDS`, 8: boards; `BOARD_W = $clog2(NUM_BOARDS)`.
- `CHANNELS_PER_BOARD`, 125: channels per board; `CH_W = $clog2(CHANNELS_PER_BOARD)`.
- `OFFSET_W`, 14: per-board ring-buffer offset width.
- `SAMPLES`, 1250: samples read per channel per trigger.
- `PRE_TRIG`, 0: samples before the snapshot offset at which readout starts.
- `ADDR_W`, 25: DRAM address width; `BOARD_W+CH_W+OFFSET_W <= ADDR_W` is required.
- `DATA_W`, 256: DRAM/PC data width.
- `clk` in 1: sole clock.
- `rst` in 1: asynchronous, active-low reset.
- `trig` in 1: trigger qualifier, sampled every cycle.
- `trig_offsets` in `NUM_BOARDS*OFFSET_W`: board b offset at `[b*OFFSET_W +: OFFSET_W]`.
- `rd_valid` out 1: read request valid.
- `rd_ready` in 1: DRAM accepts the request.
- `rd_addr` out `ADDR_W`: `{zeros, board, channel, offset}`.
- `dram_rd_data` in `DATA_W`; `dram_rd_valid` in 1: returned beats.
- `pc_data` out `DATA_W`; `pc_valid` out 1: combinational copies of `dram_rd_data` and `dram_rd_valid`.
- `busy` out 1: readout in progress (ISSUE or DRAIN).
- `done` out 1: one-cycle pulse at completion.
- `drop_count` out 16: dropped triggers, saturating.

## Operation
- States: IDLE, ISSUE, DRAIN.
- IDLE with `trig=1`: latch `base[b] = trig_offsets[b] - PRE_TRIG` (mod 2^OFFSET_W), clear counters, go to ISSUE.
- Issue order (outer to inner): sample s = 0..SAMPLES-1, board 0..NUM_BOARDS-1, channel 0..CHANNELS_PER_BOARD-1.
- Address for each request: `{board, channel, base[board] + s}`. The offset add wraps mod 2^OFFSET_W, which gives ring-buffer wraparound.
- A handshake occurs when `rd_valid & rd_ready`. Each handshake advances to the next tuple.
- While `rd_valid & !rd_ready`, `rd_addr` holds stable.
- After handshake number `TOTAL = NUM_BOARDS*CHANNELS_PER_BOARD*SAMPLES`: deassert `rd_valid` and go to DRAIN.
- A return counter counts `dram_rd_valid` beats in all states.
- In DRAIN, when the return count reaches TOTAL: pulse `done`, go to IDLE.
- If the final beat returns in the same cycle as the final handshake, the DRAIN exit still waits for the next cycle.
- A `trig` while busy is handled per Configuration.
- Counter widths: `$clog2(TOTAL+1)`.
- `drop_count` saturates at 16'hFFFF.

## Timing
- Reset values (async assert): state IDLE, `rd_valid=0`, `rd_addr=0`, `busy=0`, `done=0`, `drop_count=0`, counters 0, pending flag 0.
- Reset mid-readout aborts immediately with no `done`. Beats returning after reset are forwarded to `pc_*` but not counted.
- Latency: trigger sampled at edge T gives `rd_valid=1` with the first address after T.
- With `rd_ready` held high, one address issues per cycle, so the last request presents at cycle T+TOTAL.
- `busy` rises with the first `rd_valid` and falls in the same cycle that `done` is high.
- `done` is registered: it is high during the cycle after the edge that counts the final beat.
- `pc_*` has zero latency.

## Configuration
- `RDGEN_RETRIGGER_EN` defined:
  - A `trig` while busy with no pending trigger sets a pending flag and captures the backed-off offsets into a second snapshot.
  - On the `done` cycle the FSM returns to IDLE. On the next edge it starts from the pending snapshot, as if `trig` were asserted, and clears the flag.
  - Triggers while pending is already set are dropped and counted.
- Undefined: every `trig` while busy is dropped and increments `drop_count`. There is no pending flag or second snapshot.

## Test plan
All scenarios use NUM_BOARDS=2, CHANNELS_PER_BOARD=3, SAMPLES=2, OFFSET_W=4, PRE_TRIG=2, TOTAL=12, and `dram_rd_valid` fed back 3 cycles after each handshake unless stated.
- Basic sweep: offsets b0=5, b1=9, `rd_ready=1`, trig at T.
  - Expect 12 consecutive addresses {0,0,3},{0,1,3},{0,2,3},{1,0,7},{1,1,7},{1,2,7}, then the same with offsets 4 and 8.
  - `rd_valid` low at T+13; `done` pulses once after the 12th beat.
- Wrap: offsets b0=1, b1=0.
  - b0 offsets 15 then 0; b1 offsets 14 then 15.
- Backpressure: random `rd_ready` at 50%.
  - `rd_addr` stable whenever valid and not ready; exactly 12 handshakes in the same order as the basic sweep.
- Retrigger with macro off: trig pulses at T+4 and T+6.
  - `drop_count=2`; a single readout only.
- Retrigger with macro on: trig at T+4 with offsets b0=10, b1=12.
  - A second readout starts 1 cycle after the first `done`, with bases 8 and 10.
  - A trig at T+6 is dropped: `drop_count=1`.
- Reset mid-readout: assert `rst` low at handshake 5.
  - Outputs go to reset values asynchronously; no `done`.
  - A new trigger afterwards produces a full clean 12-read sweep.
